gfx256_zbuffer_test: RTL

//  Depth-test stage directly downstream of the colour/UV/Z interpolator.

---
 rtl/gfx256_zbuffer_test.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/gfx256_zbuffer_test.sv
// Depth-test stage: reads the stored 16-bit depth and forwards the fragment only when it is nearer.
// Define GFX256_ZBUFFER_ZWRITE_EN to write the passing depth back to the z-buffer before forwarding.
module gfx256_zbuffer_test #(
    parameter int point_width = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   write_i,
    output logic                   ack_o,
    input  logic [point_width-1:0] x_i,
    input  logic [point_width-1:0] y_i,
    input  logic [point_width-1:0] z_i,
    input  logic [31:0]            color_i,
    input  logic [7:0]             a_i,
    input  logic                   zbuffer_enable_i,
    input  logic [31:0]            zbuffer_base_i,
    input  logic [point_width-1:0] target_size_x_i,
    output logic                   z_request_o,
    output logic [31:0]            z_addr_o,
    input  logic                   z_ack_i,
    input  logic [31:0]            z_data_i,
    output logic                   write_o,
    input  logic                   ack_i,
    output logic [point_width-1:0] x_o,
    output logic [point_width-1:0] y_o,
    output logic [point_width-1:0] z_o,
    output logic [31:0]            color_o,
    output logic [7:0]             a_o,
    output logic                   zw_request_o,
    output logic [31:0]            zw_addr_o,
    output logic [31:0]            zw_data_o,
    output logic [3:0]             zw_sel_o,
    input  logic                   zw_ack_i,
    output logic [2:0]             state_o
);

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_ADDR  = 3'd1,
        S_READ  = 3'd2,
        S_CMP   = 3'd3,
        S_WRITE = 3'd4,
        S_ACK   = 3'd5
`ifdef GFX256_ZBUFFER_ZWRITE_EN
        , S_ZWR = 3'd6
`endif
    } state_t;

    state_t state, state_next;

    logic        half;
    logic [31:0] z_word;
    logic [31:0] pix_index;
    logic [31:0] byte_addr;
    logic [15:0] stored_raw;
    logic signed [point_width-1:0] stored_ext;
    logic        z_pass;
    logic        unused_sig;

    // Two bytes per pixel; the sum wraps at 32 bits like the memory address space.
    assign pix_index  = 32'(y_o) * 32'(target_size_x_i) + 32'(x_o);
    assign byte_addr  = zbuffer_base_i + {pix_index[30:0], 1'b0};
    assign stored_raw = half ? z_word[15:0] : z_word[31:16];
    assign stored_ext = point_width'($signed(stored_raw));
    assign z_pass     = $signed(z_o) < stored_ext;
    assign state_o    = state;

    always_comb begin
        state_next = state;
        case (state)
            S_WAIT:  if (write_i && !ack_o) state_next = zbuffer_enable_i ? S_ADDR : S_WRITE;
            S_ADDR:  state_next = S_READ;
            S_READ:  if (z_ack_i) state_next = S_CMP;
`ifdef GFX256_ZBUFFER_ZWRITE_EN
            S_CMP:   state_next = z_pass ? S_ZWR : S_ACK;
            S_ZWR:   if (zw_ack_i) state_next = S_WRITE;
`else
            S_CMP:   state_next = z_pass ? S_WRITE : S_ACK;
`endif
            S_WRITE: if (ack_i) state_next = S_ACK;
            S_ACK:   state_next = S_WAIT;
            default: state_next = S_WAIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_WAIT;
            ack_o       <= 1'b0;
            z_request_o <= 1'b0;
            z_addr_o    <= '0;
            write_o     <= 1'b0;
            x_o         <= '0;
            y_o         <= '0;
            z_o         <= '0;
            color_o     <= '0;
            a_o         <= '0;
            half        <= 1'b0;
            z_word      <= '0;
`ifdef GFX256_ZBUFFER_ZWRITE_EN
            zw_request_o <= 1'b0;
            zw_addr_o    <= '0;
            zw_data_o    <= '0;
            zw_sel_o     <= '0;
`endif
        end else begin
            state <= state_next;
            ack_o <= 1'b0;
            case (state)
                S_WAIT: if (write_i && !ack_o) begin
                    x_o     <= x_i;
                    y_o     <= y_i;
                    z_o     <= z_i;
                    color_o <= color_i;
                    a_o     <= a_i;
                    write_o <= !zbuffer_enable_i;
                end
                S_ADDR: begin
                    z_request_o <= 1'b1;
                    z_addr_o    <= {byte_addr[31:2], 2'b00};
                    half        <= byte_addr[1];
                end
                S_READ: if (z_ack_i) begin
                    z_word      <= z_data_i;
                    z_request_o <= 1'b0;
                end
                S_CMP: if (z_pass) begin
`ifdef GFX256_ZBUFFER_ZWRITE_EN
                    zw_request_o <= 1'b1;
                    zw_addr_o    <= z_addr_o;
                    zw_data_o    <= {2{z_o[15:0]}};
                    zw_sel_o     <= half ? 4'b0011 : 4'b1100;
`else
                    write_o <= 1'b1;
`endif
                end else begin
                    ack_o <= 1'b1;
                end
`ifdef GFX256_ZBUFFER_ZWRITE_EN
                S_ZWR: if (zw_ack_i) begin
                    zw_request_o <= 1'b0;
                    write_o      <= 1'b1;
                end
`endif
                S_WRITE: if (ack_i) begin
                    write_o <= 1'b0;
                    ack_o   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef GFX256_ZBUFFER_ZWRITE_EN
    assign unused_sig = ^{pix_index[31], byte_addr[0]};
`else
    assign zw_request_o = 1'b0;
    assign zw_addr_o    = '0;
    assign zw_data_o    = '0;
    assign zw_sel_o     = '0;
    assign unused_sig   = ^{pix_index[31], byte_addr[0], zw_ack_i};
`endif

endmodule
